rvc_lsu_align: RTL and testbench
================================

// Module: rvc_lsu_align
// PURPOSE
//  Load/store alignment unit. Sits between execute and data memory and converts byte-addressed
//  LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned accesses for a synchronous-read SRAM data memory.
//  Splits misaligned accesses into two word accesses, merges the returned read data, sign- or zero-extends
//  it, and returns one response per accepted request.
// PARAMETERS
//  ALLOW_MISALIGN  1  1: split word-crossing accesses; 0: reject them with RspErr
// PORTS
//  Clock          in   1   single clock; all state updates on the rising edge
//  Rst            in   1   asynchronous, active-low reset
//  ReqValid       in   1   request present
//  ReqReady       out  1   request accepted this cycle when ReqValid&&ReqReady
//  ReqStore       in   1   1=store, 0=load
//  ReqFunct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  ReqAddr        in   32  byte address
//  ReqWrData      in   32  store data, right-justified
//  RspValid       out  1   one-cycle pulse, exactly one per accepted request
//  RspErr         out  1   qualifies RspValid: illegal funct3, or misaligned with ALLOW_MISALIGN=0
//  RspRdData      out  32  load result, extended; 0 for stores and errors
//  MemValid       out  1   memory access this cycle
//  MemWrEn        out  1   1=write
//  MemAddr        out  32  word address, [1:0] always 00
//  MemByteEn      out  4   byte lanes
//  MemWrData      out  32  lane-aligned store data
//  MemRdData      in   32  read data for the access issued in the previous cycle
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE, hold regs=0; RspValid, RspErr, RspRdData, MemValid, MemWrEn=0.
//   Pending split or response is discarded; no memory access or RspValid follows.
//  Derived: off=ReqAddr[1:0]; size=1/2/4 from funct3[1:0]; mask=((1<<size)-1)<<off (8 bits).
//   The access splits iff off+size>4.
//  FSM: IDLE, SPLIT, RESP. ReqReady=1 in IDLE and RESP, 0 in SPLIT.
//  Accepted in IDLE or RESP:
//   - illegal, or split with ALLOW_MISALIGN=0: no MemValid; ->RESP; next cycle RspValid=1, RspErr=1.
//   - single: MemValid=1 same cycle; MemAddr={ReqAddr[31:2],2'b00}; MemByteEn=mask[3:0]; ->RESP.
//   - split: 1st access same cycle, MemByteEn=mask[3:0]; latch addr+4, mask[7:4], data, funct3; ->SPLIT.
//  SPLIT: 2nd access from latched regs; MemAddr=(base+4) mod 2^32 (0xFFFFFFFC wraps to 0); ->RESP.
//   Latch MemRdData (1st word) into the low hold reg.
//  RESP: RspValid=1. ->IDLE, or stays in RESP/goes to SPLIT if a new request is accepted this cycle.
//  Issue timing: mem outputs are combinational from Req* in IDLE/RESP and registered in SPLIT.
//  Latency: single access -> RspValid at T+1; split -> RspValid at T+2; T = accept cycle.
//  Back-to-back: one request per cycle sustained for non-split accesses.
//  Store data: MemWrData = ReqWrData rotated left by 8*off, identical for both halves. MemWrEn=ReqStore.
//  Load merge: bytes off..3 of word0 followed by bytes 0.. of word1, truncated to size.
//   Single: take bytes off..off+size-1 of MemRdData.
//   Extension: funct3[2]=0 sign-extends from the top loaded bit, 1 zero-extends.
//  Stores complete at RspValid with RspRdData=0. Load-after-store to the same word is ordered by issue order.
// TESTING
//  LW 0x1000, MemRdData=0xDEADBEEF -> T: Addr 0x1000 BE 1111; T+1: RspValid, RspRdData 0xDEADBEEF.
//  LH 0x1003, word0=0x80000000, word1=0x000000FF -> T BE 1000 @0x1000; T+1 BE 0001 @0x1004;
//   T+2: RspRdData 0xFFFFFF80 (LHU: 0x0000FF80).
//  SW 0x2002 data 0x11223344 -> T @0x2000 BE 1100 data 0x33441122; T+1 @0x2004 BE 0011 same data.
//  LB/LBU 0x3001, word 0x00008000 -> 0xFFFFFF80 / 0x00000080; back-to-back LW stream -> RspValid each cycle.
//  LW 0xFFFFFFFE -> 1st @0xFFFFFFFC BE 1100, 2nd @0x00000000 BE 0011; ALLOW_MISALIGN=0 -> no MemValid, RspErr.
//  Rst low in SPLIT -> no 2nd access, no RspValid; funct3=011 -> RspValid+RspErr at T+1, no MemValid.

Source files
------------

// File: rtl/rvc_lsu_align_if.sv
// Load/store alignment bus: execute-side request/response plus the
// word-aligned data-memory port. The alignment unit uses the slave view;
// the surrounding execute stage and memory use the master view.
interface rvc_lsu_align_if;
  // request from execute
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wr_data;
  // response to execute
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rd_data;
  // word-aligned data memory access
  logic        mem_valid;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wr_data, mem_rd_data,
    output req_ready, rsp_valid, rsp_err, rsp_rd_data,
           mem_valid, mem_wr_en, mem_addr, mem_byte_en, mem_wr_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wr_data, mem_rd_data,
    input  req_ready, rsp_valid, rsp_err, rsp_rd_data,
           mem_valid, mem_wr_en, mem_addr, mem_byte_en, mem_wr_data
  );
endinterface

// File: rtl/rvc_lsu_align.sv
// Load/store alignment unit. Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
// requests into word-aligned accesses to a synchronous-read SRAM, splitting
// word-crossing accesses in two, merging and extending load data, and
// returning exactly one response per accepted request.
module rvc_lsu_align #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  rvc_lsu_align_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // request decode
  logic [1:0]  req_off;
  logic [2:0]  req_size;
  logic        req_illegal;
  logic        req_cross;
  logic        req_reject;
  logic [7:0]  req_mask;
  logic [5:0]  rot_shift;
  logic [31:0] req_wdata_rot;
  logic [31:0] req_word_addr;
  logic        accept;

  // second-half access captured at accept of a split request
  logic [31:0] hold_addr;
  logic [3:0]  hold_be;
  logic [31:0] hold_wdata;
  logic        hold_store;

  // response context captured at accept
  logic        rsp_err_q;
  logic        rsp_store_q;
  logic [2:0]  rsp_funct3_q;
  logic [1:0]  rsp_off_q;
  logic        rsp_split_q;
  logic [31:0] rd_lo;

  // combinational memory-side and response values
  logic        ready_c;
  logic        mem_valid_c;
  logic        mem_wr_en_c;
  logic [31:0] mem_addr_c;
  logic [3:0]  mem_be_c;
  logic [31:0] mem_wdata_c;
  logic [31:0] load_lo;
  logic [31:0] load_word;
  logic [31:0] load_ext;
  logic        rsp_valid_c;

  // Decode size, lane mask, word crossing and lane-rotated store data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    req_off     = bus.req_addr[1:0];
    req_illegal = 1'b0;
    req_size    = 3'd1;
    req_mask    = 8'h00;
    case (bus.req_funct3)
      3'b000, 3'b100: req_size = 3'd1;
      3'b001, 3'b101: req_size = 3'd2;
      3'b010:         req_size = 3'd4;
      default:        req_illegal = 1'b1;
    endcase
    case (req_size)
      3'd1:    req_mask = 8'h01 << req_off;
      3'd2:    req_mask = 8'h03 << req_off;
      default: req_mask = 8'h0F << req_off;
    endcase
    req_cross  = ({1'b0, req_off} + req_size) > 3'd4;
    req_reject = req_illegal || (req_cross && !ALLOW_MISALIGN);
    // Rotate left by 8*off: the low word of {d,d} >> (32 - 8*off).
    rot_shift     = 6'd32 - {1'b0, req_off, 3'b000};
    req_wdata_rot = 32'({bus.req_wr_data, bus.req_wr_data} >> rot_shift);
    req_word_addr = {bus.req_addr[31:2], 2'b00};
  end

  // Next state and memory issue: live from the request in IDLE/RESP, from hold regs in SPLIT.
  always_comb begin
    state_nxt   = state;
    ready_c     = 1'b0;
    mem_valid_c = 1'b0;
    mem_wr_en_c = 1'b0;
    mem_addr_c  = 32'h0;
    mem_be_c    = 4'h0;
    mem_wdata_c = 32'h0;
    case (state)
      S_SPLIT: begin
        mem_valid_c = 1'b1;
        mem_wr_en_c = hold_store;
        mem_addr_c  = hold_addr;
        mem_be_c    = hold_be;
        mem_wdata_c = hold_wdata;
        state_nxt   = S_RESP;
      end
      default: begin
        ready_c   = 1'b1;
        state_nxt = S_IDLE;
        if (bus.req_valid) begin
          state_nxt = S_RESP;
          if (!req_reject) begin
            mem_valid_c = 1'b1;
            mem_wr_en_c = bus.req_store;
            mem_addr_c  = req_word_addr;
            mem_be_c    = req_mask[3:0];
            mem_wdata_c = req_wdata_rot;
            if (req_cross) state_nxt = S_SPLIT;
          end
        end
      end
    endcase
  end

  assign accept = bus.req_valid && ready_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture the second-half access and the response context on accept; latch word0 during SPLIT.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: hold registers are plain flops, so they are reset too; a pending split never survives reset.
    if (!rst_n) begin
      hold_addr    <= 32'h0;
      hold_be      <= 4'h0;
      hold_wdata   <= 32'h0;
      hold_store   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_store_q  <= 1'b0;
      rsp_funct3_q <= 3'b000;
      rsp_off_q    <= 2'b00;
      rsp_split_q  <= 1'b0;
      rd_lo        <= 32'h0;
    end else begin
      if (accept) begin
        hold_addr    <= req_word_addr + 32'd4;
        hold_be      <= req_mask[7:4];
        hold_wdata   <= req_wdata_rot;
        hold_store   <= bus.req_store;
        rsp_err_q    <= req_reject;
        rsp_store_q  <= bus.req_store;
        rsp_funct3_q <= bus.req_funct3;
        rsp_off_q    <= req_off;
        rsp_split_q  <= req_cross && !req_reject;
      end
      if (state == S_SPLIT) rd_lo <= bus.mem_rd_data;
    end
  end

  // Merge {word1, word0}, shift the first byte down to lane 0, then sign/zero extend.
  always_comb begin
    rsp_valid_c = (state == S_RESP);
    load_lo     = rsp_split_q ? rd_lo : bus.mem_rd_data;
    load_word   = 32'({bus.mem_rd_data, load_lo} >> {rsp_off_q, 3'b000});
    case (rsp_funct3_q[1:0])
      2'b00:   load_ext = rsp_funct3_q[2] ? {24'h0, load_word[7:0]}
                                          : {{24{load_word[7]}}, load_word[7:0]};
      2'b01:   load_ext = rsp_funct3_q[2] ? {16'h0, load_word[15:0]}
                                          : {{16{load_word[15]}}, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  assign bus.req_ready   = ready_c;
  assign bus.mem_valid   = mem_valid_c;
  assign bus.mem_wr_en   = mem_wr_en_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_byte_en = mem_be_c;
  assign bus.mem_wr_data = mem_wdata_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_err     = rsp_valid_c && rsp_err_q;
  assign bus.rsp_rd_data = (rsp_valid_c && !rsp_err_q && !rsp_store_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_rvc_lsu_align.sv
// Bench for rvc_lsu_align: directed requests push expected memory accesses
// and responses (with their due cycle) into queues; a monitor pops and
// compares whenever the unit presents an access or a response. A small
// memory model returns directed read words one cycle after each read.
module tb_rvc_lsu_align;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  mem_exp_t    mem_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] rd_q[$];

  rvc_lsu_align_if bus();
  rvc_lsu_align_if bus_nm();

  rvc_lsu_align #(.ALLOW_MISALIGN(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rvc_lsu_align #(.ALLOW_MISALIGN(1'b0)) u_dut_nm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every access and response against the scoreboard.
  always @(negedge clk) begin
    mem_exp_t m;
    rsp_exp_t r;
    if (rst_n) begin
      if (bus.mem_valid) begin
        if (mem_q.size() == 0) fail("mem_unexpected_access");
        else begin
          m = mem_q.pop_front();
          check("mem_cycle", 32'(cyc), 32'(m.cyc));
          check("mem_wr_en", {31'b0, bus.mem_wr_en}, {31'b0, m.wr});
          check("mem_addr", bus.mem_addr, m.addr);
          check("mem_byte_en", {28'b0, bus.mem_byte_en}, {28'b0, m.be});
          if (m.wr) check("mem_wr_data", bus.mem_wr_data, m.wd);
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected");
        else begin
          r = rsp_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(r.cyc));
          check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, r.err});
          check("rsp_rd_data", bus.rsp_rd_data, r.data);
        end
      end
    end
  end

  // Memory model: a read sampled this cycle returns its directed word next cycle.
  initial begin
    logic        rd_pend;
    logic [31:0] rd_word;
    bus.mem_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      rd_pend = rst_n && bus.mem_valid && !bus.mem_wr_en;
      rd_word = 32'h0;
      if (rd_pend) begin
        if (rd_q.size() > 0) rd_word = rd_q.pop_front();
        else fail("rd_data_underflow");
      end
      @(posedge clk);
      #1;
      if (rd_pend) bus.mem_rd_data = rd_word;
    end
  end

  // Issue one request (entered at posedge+1) and push its expected accesses and response.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int nacc,
                       input logic [31:0] a0, input logic [3:0] be0,
                       input logic [31:0] a1, input logic [3:0] be1,
                       input logic [31:0] mwd, input logic [31:0] w0, input logic [31:0] w1,
                       input logic err, input logic [31:0] rd);
    int t;
    int waits = 0;
    bus.req_valid   = 1'b1;
    bus.req_store   = st;
    bus.req_funct3  = f3;
    bus.req_addr    = addr;
    bus.req_wr_data = wd;
    while (!bus.req_ready && waits < 8) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (!bus.req_ready) begin
      fail("req_ready_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    t = cyc;
    if (nacc >= 1) begin
      mem_q.push_back('{t, st, a0, be0, mwd});
      if (!st) rd_q.push_back(w0);
    end
    if (nacc == 2) begin
      mem_q.push_back('{t + 1, st, a1, be1, mwd});
      if (!st) rd_q.push_back(w1);
    end
    rsp_q.push_back('{t + ((nacc == 2) ? 2 : 1), err, rd});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_store      = 1'b0;
    bus.req_funct3     = 3'b000;
    bus.req_addr       = 32'h0;
    bus.req_wr_data    = 32'h0;
    bus_nm.req_valid   = 1'b0;
    bus_nm.req_store   = 1'b0;
    bus_nm.req_funct3  = 3'b000;
    bus_nm.req_addr    = 32'h0;
    bus_nm.req_wr_data = 32'h0;
    bus_nm.mem_rd_data = 32'h55AA55AA;
    #3;
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    check("rst_rsp_rd_data", bus.rsp_rd_data, 32'h0);
    check("rst_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
    check("rst_mem_wr_en", {31'b0, bus.mem_wr_en}, 32'h0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //    st   f3      addr          wdata         n  a0            be0     a1            be1     mem wdata     w0            w1            err   rd
    issue(1'b0, 3'b010, 32'h00001000, 32'h0,        1, 32'h00001000, 4'hF, 32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF);
    issue(1'b0, 3'b001, 32'h00001003, 32'h0,        2, 32'h00001000, 4'h8, 32'h00001004, 4'h1, 32'h0,        32'h80000000, 32'h000000FF, 1'b0, 32'hFFFFFF80);
    issue(1'b0, 3'b101, 32'h00001003, 32'h0,        2, 32'h00001000, 4'h8, 32'h00001004, 4'h1, 32'h0,        32'h80000000, 32'h000000FF, 1'b0, 32'h0000FF80);
    issue(1'b1, 3'b010, 32'h00002002, 32'h11223344, 2, 32'h00002000, 4'hC, 32'h00002004, 4'h3, 32'h33441122, 32'h0,        32'h0,        1'b0, 32'h0);
    issue(1'b0, 3'b000, 32'h00003001, 32'h0,        1, 32'h00003000, 4'h2, 32'h0,        4'h0, 32'h0,        32'h00008000, 32'h0,        1'b0, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h00003001, 32'h0,        1, 32'h00003000, 4'h2, 32'h0,        4'h0, 32'h0,        32'h00008000, 32'h0,        1'b0, 32'h00000080);
    // back-to-back word loads: one response per cycle
    issue(1'b0, 3'b010, 32'h00004000, 32'h0,        1, 32'h00004000, 4'hF, 32'h0,        4'h0, 32'h0,        32'h01234567, 32'h0,        1'b0, 32'h01234567);
    issue(1'b0, 3'b010, 32'h00004004, 32'h0,        1, 32'h00004004, 4'hF, 32'h0,        4'h0, 32'h0,        32'h89ABCDEF, 32'h0,        1'b0, 32'h89ABCDEF);
    issue(1'b0, 3'b010, 32'h00004008, 32'h0,        1, 32'h00004008, 4'hF, 32'h0,        4'h0, 32'h0,        32'h0F0F0F0F, 32'h0,        1'b0, 32'h0F0F0F0F);
    // split across the top of the address space
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        2, 32'hFFFFFFFC, 4'hC, 32'h00000000, 4'h3, 32'h0,        32'hAABBCCDD, 32'h11223344, 1'b0, 32'h3344AABB);
    // illegal funct3: error response, no access
    issue(1'b0, 3'b011, 32'h00005000, 32'h0,        0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0,        1'b1, 32'h0);
    issue(1'b1, 3'b001, 32'h00005001, 32'h0000BEEF, 1, 32'h00005000, 4'h6, 32'h0,        4'h0, 32'h00BEEF00, 32'h0,        32'h0,        1'b0, 32'h0);
    issue(1'b0, 3'b101, 32'h00006002, 32'h0,        1, 32'h00006000, 4'hC, 32'h0,        4'h0, 32'h0,        32'h80017FFF, 32'h0,        1'b0, 32'h00008001);
    issue(1'b0, 3'b001, 32'h00006002, 32'h0,        1, 32'h00006000, 4'hC, 32'h0,        4'h0, 32'h0,        32'h80017FFF, 32'h0,        1'b0, 32'hFFFF8001);
    issue(1'b1, 3'b000, 32'h00007003, 32'h000000A5, 1, 32'h00007000, 4'h8, 32'h0,        4'h0, 32'hA5000000, 32'h0,        32'h0,        1'b0, 32'h0);
    issue(1'b0, 3'b110, 32'h00007000, 32'h0,        0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0,        1'b1, 32'h0);
    // halfword ending exactly at the word boundary does not split
    issue(1'b0, 3'b001, 32'h00001002, 32'h0,        1, 32'h00001000, 4'hC, 32'h0,        4'h0, 32'h0,        32'h7FFF0000, 32'h0,        1'b0, 32'h00007FFF);
    // split load followed immediately by another request (stalls one cycle in SPLIT)
    issue(1'b0, 3'b010, 32'h00008001, 32'h0,        2, 32'h00008000, 4'hE, 32'h00008004, 4'h1, 32'h0,        32'h44332211, 32'h88776655, 1'b0, 32'h55443322);
    issue(1'b0, 3'b010, 32'h00009000, 32'h0,        1, 32'h00009000, 4'hF, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D);
    issue(1'b1, 3'b010, 32'h00009001, 32'hA1B2C3D4, 2, 32'h00009000, 4'hE, 32'h00009004, 4'h1, 32'hB2C3D4A1, 32'h0,        32'h0,        1'b0, 32'h0);
    issue(1'b0, 3'b100, 32'h00009003, 32'h0,        1, 32'h00009000, 4'h8, 32'h0,        4'h0, 32'h0,        32'h7F000000, 32'h0,        1'b0, 32'h0000007F);
    repeat (4) @(posedge clk);
    #1;

    // Reset while in SPLIT: first access only, no second access, no response.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000A001;
    mem_q.push_back('{cyc, 1'b0, 32'h0000A000, 4'hE, 32'h0});
    rd_q.push_back(32'h12345678);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("split_rst_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
    check("split_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    check("split_rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // ALLOW_MISALIGN=0 instance: crossing access rejected, aligned one served.
    bus_nm.req_valid  = 1'b1;
    bus_nm.req_store  = 1'b0;
    bus_nm.req_funct3 = 3'b010;
    bus_nm.req_addr   = 32'hFFFFFFFE;
    #1;
    check("nm_cross_mem_valid", {31'b0, bus_nm.mem_valid}, 32'h0);
    @(posedge clk);
    #1;
    bus_nm.req_valid = 1'b0;
    #1;
    check("nm_cross_rsp_valid", {31'b0, bus_nm.rsp_valid}, 32'h1);
    check("nm_cross_rsp_err", {31'b0, bus_nm.rsp_err}, 32'h1);
    check("nm_cross_rsp_rd_data", bus_nm.rsp_rd_data, 32'h0);
    @(posedge clk);
    #1;
    bus_nm.req_valid = 1'b1;
    bus_nm.req_addr  = 32'h00001000;
    #1;
    check("nm_aligned_mem_valid", {31'b0, bus_nm.mem_valid}, 32'h1);
    check("nm_aligned_mem_addr", bus_nm.mem_addr, 32'h00001000);
    check("nm_aligned_mem_be", {28'b0, bus_nm.mem_byte_en}, 32'hF);
    @(posedge clk);
    #1;
    bus_nm.req_valid = 1'b0;
    #1;
    check("nm_aligned_rsp_valid", {31'b0, bus_nm.rsp_valid}, 32'h1);
    check("nm_aligned_rsp_err", {31'b0, bus_nm.rsp_err}, 32'h0);
    check("nm_aligned_rsp_rd_data", bus_nm.rsp_rd_data, 32'h55AA55AA);
    @(posedge clk);
    #2;
    check("nm_rsp_pulse_ends", {31'b0, bus_nm.rsp_valid}, 32'h0);

    repeat (2) @(posedge clk);
    check("mem_q_drained", 32'(mem_q.size()), 32'h0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
